// File: rtl/fact_pkg.sv
// Shared types and defaults for the iterative factorial engine (fact_core)
// and its shift-add multiplier (seq_mult).
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        MUL,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_N_WIDTH = 5;

    // One partial product per multiplier bit.
    function automatic int unsigned mult_iters(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Multi-cycle unsigned shift-add multiplier. One bit of b per cycle, so a
// product takes mult_iters(WIDTH) cycles; P_WIDTH selects how many product bits are kept.
module seq_mult
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned P_WIDTH = 2 * DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [P_WIDTH-1:0] p
);

    localparam int unsigned ITERS = mult_iters(WIDTH);
    localparam int unsigned CW    = $clog2(ITERS);

    logic [P_WIDTH-1:0] a_sh;
    logic [P_WIDTH-1:0] p_acc;
    logic [P_WIDTH-1:0] p_next;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      iter;
    logic               run;

    // done and p expose the final step combinationally, so the product is
    // usable in the last of the ITERS cycles rather than one cycle later.
    always_comb begin
        p_next = p_acc + (b_sh[0] ? a_sh : '0);
        done   = run && (iter == CW'(ITERS - 1));
        p      = p_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            p_acc <= '0;
            iter  <= '0;
            run   <= 1'b0;
        end else if (start) begin
            a_sh  <= P_WIDTH'(a);
            b_sh  <= b;
            p_acc <= '0;
            iter  <= '0;
            run   <= 1'b1;
        end else if (run) begin
            p_acc <= p_next;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            iter  <= iter + CW'(1);
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/fact_core.sv
// Iterative n! engine: FSM plus acc/cnt datapath around seq_mult.
// Define FACT_CORE_OVF_EN to keep the full product and report overflow.
module fact_core
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned N_WIDTH = DEF_N_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

`ifdef FACT_CORE_OVF_EN
    localparam int unsigned P_WIDTH = 2 * WIDTH;
`else
    localparam int unsigned P_WIDTH = WIDTH;
`endif

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [N_WIDTH-1:0] cnt;
    logic               ovf;
    logic               mult_start;
    logic               mult_done;
    logic [P_WIDTH-1:0] product;
    logic               prod_hi_nz;
    logic               last_step;

`ifdef FACT_CORE_OVF_EN
    assign prod_hi_nz = |product[P_WIDTH-1:WIDTH];
`else
    assign prod_hi_nz = 1'b0;
`endif

    assign last_step = (cnt <= N_WIDTH'(1));

    seq_mult #(
        .WIDTH   (WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mult_start),
        .a     (acc),
        .b     (WIDTH'(cnt)),
        .done  (mult_done),
        .p     (product)
    );

    always_comb begin
        state_nxt  = state;
        mult_start = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: begin
                if (last_step) begin
                    state_nxt = DONE;
                end else begin
                    mult_start = 1'b1;
                    state_nxt  = MUL;
                end
            end
            MUL:   if (mult_done) state_nxt = CHECK;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Outputs are loaded on the CHECK->DONE edge so they are valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= WIDTH'(1);
            cnt      <= '0;
            ovf      <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= n;
                        acc <= WIDTH'(1);
                        ovf <= 1'b0;
                    end
                end
                CHECK: begin
                    if (last_step) begin
                        result   <= acc;
                        overflow <= ovf;
                    end
                end
                MUL: begin
                    if (mult_done) begin
                        acc <= product[WIDTH-1:0];
                        ovf <= ovf | prod_hi_nz;
                        cnt <= cnt - N_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
